// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                operation encoding, sequencer states and iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation select encoding driven by the decode stage
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    // One result bit per cycle over the full operand width
    localparam int MULDIV_ITERS = 32;

    // MULT and DIV work on magnitudes and fix the sign afterwards
    function automatic logic op_is_signed(input logic [1:0] f_op);
        return (f_op == OP_MULT) || (f_op == OP_DIV);
    endfunction

    // Both divide encodings share the upper select bit
    function automatic logic op_is_div(input logic [1:0] f_op);
        return f_op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla32.sv
`default_nettype none
// ============================================================================
//  Module      : cla32
//  Description : Carry-lookahead adder built from generate/propagate cells.
//                4-bit lookahead groups; group carries chained in order.
//                WIDTH must be a multiple of 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int c_groups = WIDTH / 4;

    logic [WIDTH-1:0]    w_g;
    logic [WIDTH-1:0]    w_p;
    logic [WIDTH-1:0]    w_c;
    logic [c_groups-1:0] w_gg;
    logic [c_groups-1:0] w_gp;
    logic [c_groups-1:0] w_gc;

    assign w_g = x & y;
    assign w_p = x ^ y;

    // Per-group lookahead: bit carries and group generate/propagate
    for (genvar k = 0; k < c_groups; k++) begin : g_grp
        localparam int c_base = 4 * k;
        assign w_c[c_base]     = w_gc[k];
        assign w_c[c_base + 1] = w_g[c_base] | (w_p[c_base] & w_gc[k]);
        assign w_c[c_base + 2] = w_g[c_base + 1]
                               | (w_p[c_base + 1] & w_g[c_base])
                               | (w_p[c_base + 1] & w_p[c_base] & w_gc[k]);
        assign w_c[c_base + 3] = w_g[c_base + 2]
                               | (w_p[c_base + 2] & w_g[c_base + 1])
                               | (w_p[c_base + 2] & w_p[c_base + 1] & w_g[c_base])
                               | (w_p[c_base + 2] & w_p[c_base + 1] & w_p[c_base] & w_gc[k]);
        assign w_gg[k] = w_g[c_base + 3]
                       | (w_p[c_base + 3] & w_g[c_base + 2])
                       | (w_p[c_base + 3] & w_p[c_base + 2] & w_g[c_base + 1])
                       | (w_p[c_base + 3] & w_p[c_base + 2] & w_p[c_base + 1] & w_g[c_base]);
        assign w_gp[k] = &w_p[c_base +: 4];
    end

    // Group carry chain; a block-local running carry keeps the chain acyclic
    always_comb begin
        logic v_carry;
        v_carry = c_in;
        for (int k = 0; k < c_groups; k++) begin
            w_gc[k] = v_carry;
            v_carry = w_gg[k] | (w_gp[k] & v_carry);
        end
        c_out = v_carry;
    end

    assign sum = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                One bit per cycle through a single shared CLA adder,
//                followed by one sign-fix cycle.
//                Macro MULDIV_DIV_EN: when defined, the restoring divider is
//                built; otherwise DIV/DIVU retire in one cycle leaving HI/LO
//                untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned        c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam int                 c_w2       = 2 * WIDTH;
    localparam logic [1:0]         c_st_idle  = ST_IDLE;
    localparam logic [1:0]         c_st_calc  = ST_CALC;
    localparam logic [1:0]         c_st_fix   = ST_FIX;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_part;     // upper product half / remainder
    logic [WIDTH-1:0]   r_low;      // multiplier then low product / dividend then quotient
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_lo;   // negate product / quotient in FIX
    logic               r_done;

`ifdef MULDIV_DIV_EN
    logic               r_neg_rem;  // remainder follows the dividend sign
    logic               r_div0;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   w_rem_sh;
    logic               w_no_borrow;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
`endif

    logic               w_signed;
    logic               w_launch_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_add_x;
    logic [WIDTH-1:0]   w_add_y;
    logic               w_add_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_calc_part;
    logic [WIDTH-1:0]   w_calc_low;
    logic [c_w2-1:0]    w_prod;
    logic [c_w2-1:0]    w_prod_fix;

    // Magnitudes at launch; the most negative value maps onto itself as unsigned
    assign w_signed     = op_is_signed(op);
    assign w_launch_div = op_is_div(op);
    assign w_a_mag      = (w_signed && a[WIDTH-1]) ? ((~a) + WIDTH'(1)) : a;
    assign w_b_mag      = (w_signed && b[WIDTH-1]) ? ((~b) + WIDTH'(1)) : b;

    cla32 #(
        .WIDTH (WIDTH)
    ) u_cla (
        .x     (w_add_x),
        .y     (w_add_y),
        .c_in  (w_add_cin),
        .sum   (w_sum),
        .c_out (w_cout)
    );

`ifdef MULDIV_DIV_EN
    // Shifted remainder; its dropped MSB makes the 33-bit trial never borrow
    assign w_rem_sh    = {r_part[WIDTH-2:0], r_low[WIDTH-1]};
    assign w_no_borrow = r_part[WIDTH-1] | w_cout;
    assign w_quot_fix  = r_neg_lo  ? ((~r_low)  + WIDTH'(1)) : r_low;
    assign w_rem_fix   = r_neg_rem ? ((~r_part) + WIDTH'(1)) : r_part;
`endif

    // Adder operand steering: add multiplicand, or subtract divisor
    always_comb begin
        w_add_x   = r_part;
        w_add_y   = r_low[0] ? r_mcand : '0;
        w_add_cin = 1'b0;
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
            w_add_x   = w_rem_sh;
            w_add_y   = ~r_mcand;
            w_add_cin = 1'b1;
        end
`endif
    end

    // Next partial/low pair for one iteration
    always_comb begin
        w_calc_part = {w_cout, w_sum[WIDTH-1:1]};
        w_calc_low  = {w_sum[0], r_low[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
            w_calc_part = w_no_borrow ? w_sum : w_rem_sh;
            w_calc_low  = {r_low[WIDTH-2:0], w_no_borrow};
        end
`endif
    end

    assign w_prod     = {r_part, r_low};
    assign w_prod_fix = r_neg_lo ? ((~w_prod) + c_w2'(1)) : w_prod;

    // Sequencer, datapath registers and HI/LO ownership
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_part   <= '0;
            r_low    <= '0;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_orig  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    if (start && !cancel) begin
                        r_part   <= '0;
                        r_cnt    <= '0;
                        r_low    <= w_launch_div ? w_a_mag : w_b_mag;
                        r_mcand  <= w_launch_div ? w_b_mag : w_a_mag;
                        r_neg_lo <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_is_div <= w_launch_div;
`ifdef MULDIV_DIV_EN
                        r_neg_rem <= w_signed & a[WIDTH-1];
                        r_div0    <= (b == '0);
                        r_a_orig  <= a;
                        r_state   <= c_st_calc;
`else
                        r_state   <= w_launch_div ? c_st_fix : c_st_calc;
`endif
                    end
                end
                c_st_calc: begin
                    if (cancel) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_part <= w_calc_part;
                        r_low  <= w_calc_low;
                        r_cnt  <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_last) r_state <= c_st_fix;
                    end
                end
                c_st_fix: begin
                    r_state <= c_st_idle;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod_fix[c_w2-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
`ifdef MULDIV_DIV_EN
                        else if (r_div0) begin
                            r_hi <= r_a_orig;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
`endif
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = (r_state != c_st_idle);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq against an arithmetic
//                reference model of HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference architectural HI/LO
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Arithmetic meaning of each operation, applied to the reference HI/LO
    function automatic void ref_op(input logic [1:0] f_op, input logic [W-1:0] fa,
                                   input logic [W-1:0] fb);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (f_op)
            2'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'd1: begin p = {32'd0, fa} * {32'd0, fb}; m_hi = p[63:32]; m_lo = p[31:0]; end
            default: begin
                if (DIV_EN) begin
                    if (fb == '0) begin
                        m_hi = fa;
                        m_lo = 32'hFFFF_FFFF;
                    end else if (f_op == 2'd2) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        m_lo = sq[31:0];
                        m_hi = sr[31:0];
                    end else begin
                        m_lo = fa / fb;
                        m_hi = fa % fb;
                    end
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] f_op);
        return (f_op[1] && !DIV_EN) ? 1 : 33;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(1, 1000));
            default: return 32'($urandom);
        endcase
    endfunction

    // Launch one op at the current negedge; returns edges-to-done and busy shape
    task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic t_wh, input logic t_wl, input logic [W-1:0] t_wd,
                         output int lat, output bit busy_ok);
        op = t_op; a = ta; b = tb_v; start = 1'b1;
        wr_hi = t_wh; wr_lo = t_wl; wdata = t_wd;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        a = $urandom; b = $urandom; wdata = $urandom;
        lat = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    // MTHI then MTLO from IDLE
    task automatic mt_write(input logic [W-1:0] h, input logic [W-1:0] l);
        wr_hi = 1'b1; wdata = h;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = l;
        @(negedge clk);
        wr_lo = 1'b0;
        m_hi = h;
        m_lo = l;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        #1;
        n_checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL reset_async: busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL reset_held: busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[8];
        int   lat;
        bit   bok;
        logic [W-1:0] eh, el;
        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[5] = '{2'd3, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{2'd1, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A};
        for (int k = 0; k < 8; k++) begin
            if (vecs[k].op[1] && !DIV_EN) begin
                eh = m_hi; el = m_lo;
            end else begin
                eh = vecs[k].hi; el = vecs[k].lo;
            end
            do_op(vecs[k].op, vecs[k].a, vecs[k].b, 1'b0, 1'b0, '0, lat, bok);
            n_checks++;
            if (lat !== exp_lat(vecs[k].op)) begin
                n_errors++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", k, lat, exp_lat(vecs[k].op));
            end
            n_checks++;
            if ({hi, lo} !== {eh, el}) begin
                n_errors++;
                $display("FAIL directed[%0d] result: hi=%h lo=%h expected hi=%h lo=%h", k, hi, lo, eh, el);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_errors++;
                $display("FAIL directed[%0d] busy_shape: got %b expected 1", k, bok);
            end
            m_hi = eh;
            m_lo = el;
        end
    endtask

    // Consecutive random ops, each launched in the previous done cycle
    task automatic test_random_back_to_back();
        logic [1:0]   r_op;
        logic [W-1:0] ra, rb, wd;
        logic         wh, wl;
        int           lat;
        bit           bok;
        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            wh = ($urandom_range(0, 4) == 0);
            wl = ($urandom_range(0, 4) == 0);
            wd = $urandom;
            do_op(r_op, ra, rb, wh, wl, wd, lat, bok);
            if (wh) m_hi = wd;
            if (wl) m_lo = wd;
            ref_op(r_op, ra, rb);
            n_checks++;
            if (lat !== exp_lat(r_op)) begin
                n_errors++;
                $display("FAIL random[%0d] latency op=%0d: got %0d expected %0d", k, r_op, lat, exp_lat(r_op));
            end
            n_checks++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                n_errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h expected hi=%h lo=%h",
                         k, r_op, ra, rb, hi, lo, m_hi, m_lo);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_errors++;
                $display("FAIL random[%0d] busy_shape: got %b expected 1", k, bok);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse_width: done=%b one cycle after done, expected 0", done);
        end
    endtask

    task automatic test_cancel();
        bit seen;
        mt_write(32'h0000_1234, 32'h0000_5678);
        n_checks++;
        if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678}) begin
            n_errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h expected hi=00001234 lo=00005678", hi, lo);
        end
        op = 2'd1; a = $urandom | 32'h1; b = $urandom | 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL cancel_pre: busy=%b before cancel edge, expected 1", busy);
        end
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL cancel_calc: busy=%b done=%b after cancel, expected 0 0", busy, done);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || {hi, lo} !== {32'h0000_1234, 32'h0000_5678}) begin
            n_errors++;
            $display("FAIL cancel_quiet: activity=%b hi=%h lo=%h expected 0 00001234 00005678", seen, hi, lo);
        end
        // Cancel beats start in IDLE
        op = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
            n_errors++;
            $display("FAIL cancel_idle: activity=%b hi=%h lo=%h expected 0 %h %h", seen, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        lat = -1;
        op = 2'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 4) begin
                start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'd9;
                wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (i == 5) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
                n_checks++;
                if ({hi, lo} !== {m_hi, m_lo}) begin
                    n_errors++;
                    $display("FAIL busy_write_ignored: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
                end
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        m_hi = '0;
        m_lo = 32'd15;
        n_checks++;
        if (lat !== 33 || {hi, lo} !== {m_hi, m_lo}) begin
            n_errors++;
            $display("FAIL busy_start_ignored: lat=%0d hi=%h lo=%h expected 33 00000000 0000000f", lat, hi, lo);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL no_queue: busy=%b done=%b after done, expected 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        bit bok;
        mt_write(32'h0000_AAAA, 32'h0000_BBBB);
        op = 2'd1; a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL reset_mid_calc: busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        do_op(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0, lat, bok);
        n_checks++;
        if (lat !== 33 || {hi, lo} !== {32'd0, 32'd42}) begin
            n_errors++;
            $display("FAIL after_reset_multu: lat=%0d hi=%h lo=%h expected 33 00000000 0000002a", lat, hi, lo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_cancel();
        test_ignore_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
